// File: rtl/croc_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : croc_rst_seq
// Brief    : Staggered domain reset release, fetch-enable sequencing and
//            per-domain soft reset for the SoC top level.
// Revision : 1.0
// ============================================================================
module croc_rst_seq #(
  parameter int NumDomains = 2,
  parameter int SyncStages = 2,
  parameter int HoldCycles = 8,
  parameter int ReleaseGap = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  testmode_i,
  input  logic                  fetch_en_i,
  input  logic [NumDomains-1:0] sw_rst_req_i,
  input  logic                  core_busy_i,
  output logic [NumDomains-1:0] domain_rst_no,
  output logic                  fetch_en_o,
  output logic                  seq_done_o,
  output logic                  status_o
);

  localparam int c_CNT_MAX = (HoldCycles > ReleaseGap) ? HoldCycles : ReleaseGap;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_IDX_W   = $clog2(NumDomains + 1);
  localparam int c_SRC_W   = $clog2(HoldCycles + 1);

  typedef enum logic [1:0] {
    ST_HOLD       = 2'd0,
    ST_RELEASE    = 2'd1,
    ST_WAIT_FETCH = 2'd2,
    ST_RUN        = 2'd3
  } state_e;

  state_e                  r_state;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_IDX_W-1:0]      r_idx;
  logic [SyncStages-1:0]   r_sync;
  logic                    r_fetch_en;
  logic                    r_seq_done;
  logic                    r_status;
  logic [NumDomains-1:0]   w_dom_n;
  logic [NumDomains-1:0]   w_rel_pulse;
  logic                    w_active;
  logic                    w_fen_s;
  logic                    w_req0;

  assign w_active = (r_state == ST_WAIT_FETCH) || (r_state == ST_RUN);
  assign w_fen_s  = r_sync[SyncStages-1];
  assign w_req0   = sw_rst_req_i[0] & w_active;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], fetch_en_i};
    end
  end

  // Each domain owns its release flag and soft-reset counter; the sequencer
  // only supplies a one-edge release pulse.
  for (genvar k = 0; k < NumDomains; k++) begin : g_dom
    logic [c_SRC_W-1:0] r_scnt;
    logic               r_dom_n;
    logic               w_req;

    assign w_req      = sw_rst_req_i[k] & w_active;
    assign w_dom_n[k] = r_dom_n;

    if (k == 0) begin : g_first
      assign w_rel_pulse[k] = (r_state == ST_HOLD) &&
                              (r_cnt == c_CNT_W'(HoldCycles - 1));
    end else begin : g_rest
      assign w_rel_pulse[k] = (r_state == ST_RELEASE) &&
                              (r_cnt == c_CNT_W'(ReleaseGap - 1)) &&
                              (r_idx == c_IDX_W'(k));
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_scnt  <= '0;
        r_dom_n <= 1'b0;
      end else if (w_req) begin
        r_scnt  <= c_SRC_W'(HoldCycles);
        r_dom_n <= 1'b0;
      end else if (r_scnt != '0) begin
        r_scnt  <= r_scnt - c_SRC_W'(1);
        r_dom_n <= (r_scnt == c_SRC_W'(1));
      end else if (w_rel_pulse[k]) begin
        r_dom_n <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_HOLD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_fetch_en <= 1'b0;
      r_seq_done <= 1'b0;
      r_status   <= 1'b0;
    end else begin
      r_status <= core_busy_i & r_fetch_en;
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == c_CNT_W'(HoldCycles - 1)) begin
            r_cnt   <= '0;
            r_idx   <= c_IDX_W'(1);
            r_state <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_idx == c_IDX_W'(NumDomains)) begin
            r_cnt      <= '0;
            r_seq_done <= 1'b1;
            r_state    <= ST_WAIT_FETCH;
          end else if (r_cnt == c_CNT_W'(ReleaseGap - 1)) begin
            r_cnt <= '0;
            r_idx <= r_idx + c_IDX_W'(1);
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        ST_WAIT_FETCH: begin
          // The core must be out of soft reset before fetch may start.
          if (w_req0) begin
            r_fetch_en <= 1'b0;
          end else if (w_fen_s && w_dom_n[0]) begin
            r_fetch_en <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_req0 || !w_fen_s) begin
            r_fetch_en <= 1'b0;
            r_state    <= ST_WAIT_FETCH;
          end
        end
        default: begin
          r_state    <= ST_HOLD;
          r_cnt      <= '0;
          r_idx      <= '0;
          r_fetch_en <= 1'b0;
          r_seq_done <= 1'b0;
        end
      endcase
    end
  end

  assign domain_rst_no = testmode_i ? {NumDomains{~rst_i}} : w_dom_n;
  assign fetch_en_o    = r_fetch_en;
  assign seq_done_o    = r_seq_done;
  assign status_o      = r_status;

endmodule
`default_nettype wire
